uart_frame_rx: RTL and testbench

Parametrised serial frame receiver: oversamples an asynchronous UART line and assembles a checksummed multi-byte frame into a PAYLOAD_BITS-wide parallel word, e.g. a board-state snapshot.
- Adds start-bit glitch rejection, stop-bit checking, sync-byte framing, an XOR checksum, an inter-byte timeout and error reporting.
- Sits between the board-level rx pin and the consumer logic that latches data_out on ready.

---
 rtl/uart_frame_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// Serial frame receiver: oversamples a UART line (8N1, LSB first), hunts for a
// sync byte, collects NBYTES payload bytes plus an XOR checksum byte and
// presents the payload on data_out with a one-cycle ready pulse. Aborted frames
// (framing error, checksum mismatch, inter-byte silence) give a one-cycle err
// pulse with a cause code.
module uart_frame_rx #(
    parameter int         CLKS_PER_BIT = 564,
    parameter int         PAYLOAD_BITS = 162,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rx,
    output logic [PAYLOAD_BITS-1:0] data_out,
    output logic                    ready,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int NBYTES = (PAYLOAD_BITS + 7) / 8;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMAX   = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TMAX);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
    typedef enum logic [1:0] {F_HUNT, F_PAYLOAD, F_CHECK} frame_state_e;

    logic rxMeta_q, rxSync_q;

    byte_state_e      byteState_q, byteState_d;
    logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       rxByte_q, rxByte_d;
    logic             byteValid_q, byteValid_d;
    logic             frameErr_q, frameErr_d;

    frame_state_e            fState_q, fState_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              chk_q, chk_d;
    logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
    logic [PAYLOAD_BITS-1:0] dataOut_q, dataOut_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [1:0]              errCode_q, errCode_d;
    logic [TO_W-1:0]         silence_q, silence_d;

    logic startDet;

    assign startDet = (byteState_q == B_IDLE) && !rxSync_q;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Byte FSM state and datapath registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            byteState_q <= B_IDLE;
            clkCnt_q    <= '0;
            bitCnt_q    <= '0;
            rxByte_q    <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            byteState_q <= byteState_d;
            clkCnt_q    <= clkCnt_d;
            bitCnt_q    <= bitCnt_d;
            rxByte_q    <= rxByte_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Byte FSM: mid-bit sampling with start glitch rejection and stop check.
    always_comb begin
        byteState_d = byteState_q;
        clkCnt_d    = clkCnt_q + CNT_W'(1);
        bitCnt_d    = bitCnt_q;
        rxByte_d    = rxByte_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        case (byteState_q)
            B_IDLE: begin
                clkCnt_d = '0;
                bitCnt_d = '0;
                if (!rxSync_q) byteState_d = B_START;
            end
            B_START: begin
                if (clkCnt_q == HALF_M1) begin
                    clkCnt_d    = '0;
                    byteState_d = rxSync_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (clkCnt_q == FULL_M1) begin
                    clkCnt_d = '0;
                    rxByte_d = {rxSync_q, rxByte_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) byteState_d = B_STOP;
                end
            end
            B_STOP: begin
                if (clkCnt_q == FULL_M1) begin
                    clkCnt_d    = '0;
                    byteValid_d = rxSync_q;
                    frameErr_d  = !rxSync_q;
                    byteState_d = B_IDLE;
                end
            end
            default: byteState_d = B_IDLE;
        endcase
    end

    // Frame FSM state, payload shadow and registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fState_q  <= F_HUNT;
            idx_q     <= '0;
            chk_q     <= '0;
            shadow_q  <= '0;
            dataOut_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 2'b00;
            silence_q <= '0;
        end else begin
            fState_q  <= fState_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            shadow_q  <= shadow_d;
            dataOut_q <= dataOut_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
            silence_q <= silence_d;
        end
    end

    // Frame FSM: sync hunt, payload collection, checksum and silence timeout.
    always_comb begin
        fState_d  = fState_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        shadow_d  = shadow_q;
        dataOut_d = dataOut_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        errCode_d = 2'b00;
        silence_d = silence_q;
        if (fState_q == F_HUNT) begin
            silence_d = '0;
            if (byteValid_q && (rxByte_q == SYNC_BYTE)) begin
                fState_d = F_PAYLOAD;
                idx_d    = '0;
                chk_d    = '0;
            end
        end else if (frameErr_q) begin
            err_d     = 1'b1;
            errCode_d = 2'b01;
            fState_d  = F_HUNT;
        end else if (byteValid_q) begin
            if (fState_q == F_PAYLOAD) begin
                for (int b = 0; b < PAYLOAD_BITS; b++) begin
                    if (idx_q == IDX_W'(b / 8)) shadow_d[b] = rxByte_q[3'(b % 8)];
                end
                chk_d = chk_q ^ rxByte_q;
                if (idx_q == LAST_IDX) fState_d = F_CHECK;
                else                   idx_d    = idx_q + IDX_W'(1);
            end else begin
                if (rxByte_q == chk_q) begin
                    dataOut_d = shadow_q;
                    ready_d   = 1'b1;
                end else begin
                    err_d     = 1'b1;
                    errCode_d = 2'b10;
                end
                fState_d = F_HUNT;
            end
        end else if (startDet) begin
            silence_d = '0;
        end else if (byteState_q == B_IDLE) begin
            if (silence_q == TO_LIMIT) begin
                err_d     = 1'b1;
                errCode_d = 2'b11;
                fState_d  = F_HUNT;
            end else begin
                silence_d = silence_q + TO_W'(1);
            end
        end
    end

    assign data_out = dataOut_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign err_code = errCode_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: a vector table of whole frames with
// expected outcomes, a scoreboard queue popped on every ready/err pulse, and
// hand-written glitch and mid-byte reset sequences.
module tb_uart_frame_rx;

   localparam int CPB = 4;
   localparam int PB  = 12;
   localparam int TOB = 4;
   localparam int GAP = 80;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          rx     = 1'b1;
   logic [PB-1:0] data_out;
   logic          ready;
   logic          err;
   logic [1:0]    err_code;

   uart_frame_rx #(
      .CLKS_PER_BIT(CPB),
      .PAYLOAD_BITS(PB),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_BITS(TOB)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rx(rx),
      .data_out(data_out),
      .ready(ready),
      .err(err),
      .err_code(err_code)
   );

   // Free-running 100 MHz clock.
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic          isErr;
      logic [1:0]    code;
      logic [PB-1:0] data;
   } exp_t;

   typedef struct {
      string         name;
      int            n;
      logic [47:0]   bytes;
      logic          lastStop;
      int            expKind;
      logic [1:0]    expCode;
      logic [PB-1:0] expData;
   } vec_t;

   exp_t          sbQ[$];
   exp_t          monExp;
   vec_t          vecs[7];
   int            total = 0;
   int            bad   = 0;
   logic [PB-1:0] modelData = '0;

   // Scoreboard monitor: every ready/err pulse must match the oldest expectation.
   always @(negedge clk_in) begin
      if (rst_in && (ready || err)) begin
         total++;
         if (ready && err) begin
            bad++;
            $display("[TB] FAIL pulse_overlap: ready=%0b err=%0b, required not both", ready, err);
         end else if (sbQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_pulse: ready=%0b err=%0b code=%0b, required no pulse",
                     ready, err, err_code);
         end else begin
            monExp = sbQ.pop_front();
            if ((monExp.isErr != err) || (err && (err_code != monExp.code)) ||
                (ready && (data_out != monExp.data))) begin
               bad++;
               $display("[TB] FAIL pulse_result: got err=%0b code=%0b data=%h, required err=%0b code=%0b data=%h",
                        err, err_code, data_out, monExp.isErr, monExp.code, monExp.data);
            end
         end
      end
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic checkOutput(input string name);
      checkVal({name, "_data"}, 32'(data_out), 32'(modelData));
      checkVal({name, "_quiet"}, {28'd0, ready, err, err_code}, 32'd0);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk_in);
      end
      rx = stopBit;
      repeat (CPB) @(negedge clk_in);
      rx = 1'b1;
   endtask

   task automatic waitDrain(input string name);
      int cyc;
      cyc = 0;
      while (sbQ.size() != 0 && cyc < 3000) begin
         @(negedge clk_in);
         cyc++;
      end
      if (sbQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_drain: %0d expected pulses missing, required 0", name, sbQ.size());
         sbQ.delete();
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      if (v.expKind == 1) begin
         e.isErr = 1'b0; e.code = 2'b00; e.data = v.expData;
         sbQ.push_back(e);
         modelData = v.expData;
      end else if (v.expKind == 2) begin
         e.isErr = 1'b1; e.code = v.expCode; e.data = '0;
         sbQ.push_back(e);
      end
      for (int i = 0; i < v.n; i++) begin
         sendByte(v.bytes[8*i +: 8], (i == v.n - 1) ? v.lastStop : 1'b1);
      end
      repeat (GAP) @(negedge clk_in);
      waitDrain(v.name);
      checkOutput(v.name);
   endtask

   initial begin
      vecs[0] = '{"valid234",   4, 48'h0000_2612_34A5, 1'b1, 1, 2'b00, 12'h234};
      vecs[1] = '{"badchk",     4, 48'h0000_2712_34A5, 1'b1, 2, 2'b10, 12'h000};
      vecs[2] = '{"framing",    3, 48'h0000_0012_34A5, 1'b0, 2, 2'b01, 12'h000};
      vecs[3] = '{"valid756",   4, 48'h0000_5107_56A5, 1'b1, 1, 2'b00, 12'h756};
      vecs[4] = '{"noisesync",  6, 48'h2612_34A5_3CFF, 1'b1, 1, 2'b00, 12'h234};
      vecs[5] = '{"timeout",    2, 48'h0000_0000_34A5, 1'b1, 2, 2'b11, 12'h000};
      vecs[6] = '{"valid978",   4, 48'h0000_7109_78A5, 1'b1, 1, 2'b00, 12'h978};

      repeat (3) @(negedge clk_in);
      checkVal("reset_data", 32'(data_out), 32'd0);
      checkVal("reset_ready", 32'(ready), 32'd0);
      checkVal("reset_err", 32'(err), 32'd0);
      checkVal("reset_code", 32'(err_code), 32'd0);
      rst_in = 1'b1;
      repeat (5) @(negedge clk_in);

      for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

      $display("[TB] glitch rejection");
      rx = 1'b0;
      @(negedge clk_in);
      rx = 1'b1;
      repeat (10) @(negedge clk_in);
      applyStimulus(vecs[0]);

      $display("[TB] reset mid-byte");
      rx = 1'b0;
      repeat (CPB) @(negedge clk_in);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      modelData = '0;
      checkVal("midreset_data", 32'(data_out), 32'd0);
      checkVal("midreset_pulses", {28'd0, ready, err, err_code}, 32'd0);
      rx = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      repeat (20) @(negedge clk_in);
      checkOutput("postreset");
      applyStimulus(vecs[3]);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
